ifm_feeder: RTL and testbench
=============================

// Module: ifm_feeder
// PURPOSE
// - Producer side of the rf_ifm interface: fetches an IFM_H x IFM_W int8 feature map from SRAM and
//   drives three rf_ifm row buffers (rows r, r+1, r+2) with one column per ifm_read pulse.
// - Raster order, stride 1, no padding. Flags when the three rf_ifm instances hold a full 3x3 window.
// - Sits between the ifm SRAM and the CU33 window registers, upstream of the PE array.
// PARAMETERS
// - IFM_H   8   feature-map height, >= 3
// - IFM_W   8   feature-map width, >= 3
// - ADDR_W  12  SRAM address width; all address arithmetic is modulo 2**ADDR_W
// PORTS
// - clk          in   1       clock
// - rstn         in   1       asynchronous active-low reset
// - start        in   1       begin a map; sampled only in IDLE
// - ifm_base     in   ADDR_W  address of pixel (0,0); sampled with accepted start
// - stall        in   1       downstream not ready; blocks the PUSH handshake
// - mem_rd_en    out  1       SRAM read strobe
// - mem_addr     out  ADDR_W  SRAM read address
// - mem_rd_data  in   8       signed SRAM data, valid 1 cycle after mem_rd_en
// - ifm_read     out  1       shift strobe to all three rf_ifm
// - ifm_in0/1/2  out  8       signed pixels, rows r / r+1 / r+2, column c
// - win_valid    out  1       1-cycle pulse: rf_ifm buffers hold columns c-2..c
// - win_row      out  clog2(IFM_H)  output-window row r, valid with win_valid
// - win_col      out  clog2(IFM_W)  output-window column c-2, valid with win_valid
// - busy         out  1       high outside IDLE
// - done         out  1       1-cycle pulse after last column of last row is pushed
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; r, c, k, column registers 0. Reset mid-map aborts, no done.
// - FSM: IDLE -> FETCH (start) ; FETCH k=0..2, one read per cycle, addr = ifm_base+(r+k)*IFM_W+c
//   -> LAST (captures k=2 data) -> PUSH -> FETCH for next column, or DONE after final column -> IDLE.
// - Read data registered into col[k] the cycle after the read of lane k; ifm_in0/1/2 = col[0..2].
// - PUSH: ifm_read=1 only when stall=0; while stall=1 state holds, outputs hold, no SRAM reads.
// - Handshake completes in the PUSH cycle with stall=0; c increments; at c=IFM_W-1 c wraps to 0, r++.
// - Unstalled cadence: 5 cycles per column (F,F,F,L,P); start accepted cycle 0 -> first ifm_read cycle 5.
// - win_valid registered: asserted the cycle after a completed push whose column c >= 2;
//   win_row=r, win_col=c-2 of that push. Pushes with c<2 never raise win_valid (stale prior-row data).
// - Rows iterate r = 0..IFM_H-3; total pushes (IFM_H-2)*IFM_W; windows (IFM_H-2)*(IFM_W-2).
// - done: asserted in the cycle after the final push (same cycle as the final win_valid); busy drops then.
// - start while busy ignored; start and done same cycle: start ignored (FSM in DONE, not IDLE).
// - Address: row base register += IFM_W per row, lane offsets +IFM_W/+2*IFM_W; wraps silently.
// - mem_addr is 0 whenever mem_rd_en=0.
// STRUCTURE
// - cu33_pkg: DATA_W=8, ifm_feeder state enum (IDLE, FETCH, LAST, PUSH, DONE), shared pixel typedef.
// - Sub-module ifm_addr_gen: r/c/k counters and row-base accumulator, outputs mem_addr and last flags.
// - Top: FSM, column capture registers, win flags. SVA: ifm_read never while stall; one-hot pulses.
// TESTING (IFM_H=IFM_W=4, ifm_base=0, mem[i]=i unless stated)
// - Basic: start cycle 0, stall=0 -> ifm_read at cycles 5,10,...,40; first push ifm_in0/1/2=0,4,8;
//   first win_valid cycle 16 with win_row=0,win_col=0, ifm_in=2,6,10; 4 windows total; done cycle 41.
// - Stall: hold stall=1 cycles 5..9 -> ifm_read first at cycle 10, outputs stable, mem_rd_en=0 meanwhile.
// - Base/wrap: ADDR_W=4, ifm_base=14 -> first reads at addrs 14,2,6 (mod 16).
// - Start while busy at cycle 7 -> ignored, counts unchanged; start after done -> second full map.
// - Reset mid-map at cycle 23 -> all outputs 0 next cycle, no done; restart yields basic-test trace.
// - Scoreboard run IFM_H=5,IFM_W=7 random mem, random stall -> 15 windows matching golden 3x3 columns.

Source files
------------

// File: rtl/cu33_pkg.sv
// Shared types and constants for the CU33 input-feature-map path.
package cu33_pkg;
   localparam int DATA_W    = 8;
   localparam int ROW_LANES = 3;

   typedef logic signed [DATA_W-1:0] pixel_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LAST,
      PUSH,
      DONE
   } ifm_state_e;
endpackage

// File: rtl/ifm_addr_gen.sv
// Row/column/lane counters and row-base accumulator for the ifm feeder.
// All address arithmetic wraps modulo 2**ADDR_W.
module ifm_addr_gen
   import cu33_pkg::*;
#(
   parameter int IFM_H  = 8,
   parameter int IFM_W  = 8,
   parameter int ADDR_W = 12,
   parameter int ROW_W  = 3,
   parameter int COL_W  = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              k_step_i,
   input  logic              push_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [1:0]        k_o,
   output logic [ROW_W-1:0]  r_o,
   output logic [COL_W-1:0]  c_o,
   output logic              k_last_o,
   output logic              c_last_o,
   output logic              r_last_o
);
   localparam logic [ADDR_W-1:0] W1_A = ADDR_W'(IFM_W);
   localparam logic [ADDR_W-1:0] W2_A = ADDR_W'(2 * IFM_W);

   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ROW_W-1:0]  r_q, r_d;
   logic [COL_W-1:0]  c_q, c_d;
   logic [1:0]        k_q, k_d;
   logic [ADDR_W-1:0] lane_off;

   assign k_last_o = (k_q == 2'd2);
   assign c_last_o = (c_q == COL_W'(IFM_W - 1));
   assign r_last_o = (r_q == ROW_W'(IFM_H - ROW_LANES));

   always_comb begin
      case (k_q)
         2'd1:    lane_off = W1_A;
         2'd2:    lane_off = W2_A;
         default: lane_off = '0;
      endcase
   end

   assign addr_o = row_base_q + lane_off + ADDR_W'(c_q);
   assign k_o    = k_q;
   assign r_o    = r_q;
   assign c_o    = c_q;

   always_comb begin
      row_base_d = row_base_q;
      r_d        = r_q;
      c_d        = c_q;
      k_d        = k_q;
      if (load_i) begin
         row_base_d = base_i;
         r_d        = '0;
         c_d        = '0;
         k_d        = '0;
      end else begin
         if (k_step_i) begin
            k_d = k_last_o ? 2'd0 : k_q + 2'd1;
         end
         // End of a row: advance the base by one row instead of recomputing r*IFM_W.
         if (push_i) begin
            if (c_last_o) begin
               c_d        = '0;
               r_d        = r_q + ROW_W'(1);
               row_base_d = row_base_q + W1_A;
            end else begin
               c_d = c_q + COL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_base_q <= '0;
         r_q        <= '0;
         c_q        <= '0;
         k_q        <= '0;
      end else begin
         row_base_q <= row_base_d;
         r_q        <= r_d;
         c_q        <= c_d;
         k_q        <= k_d;
      end
   end
endmodule

// File: rtl/ifm_feeder.sv
// Fetches an IFM_H x IFM_W int8 map from SRAM and feeds three rf_ifm row buffers one
// column at a time (raster order, stride 1), flagging each complete 3x3 window.
module ifm_feeder
   import cu33_pkg::*;
#(
   parameter int IFM_H  = 8,
   parameter int IFM_W  = 8,
   parameter int ADDR_W = 12
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          ifm_base,
   input  logic                       stall,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic signed [DATA_W-1:0]   mem_rd_data,
   output logic                       ifm_read,
   output logic signed [DATA_W-1:0]   ifm_in0,
   output logic signed [DATA_W-1:0]   ifm_in1,
   output logic signed [DATA_W-1:0]   ifm_in2,
   output logic                       win_valid,
   output logic [$clog2(IFM_H)-1:0]   win_row,
   output logic [$clog2(IFM_W)-1:0]   win_col,
   output logic                       busy,
   output logic                       done
);
   localparam int ROW_W = $clog2(IFM_H);
   localparam int COL_W = $clog2(IFM_W);

   ifm_state_e        state_q;
   pixel_t            col_q [ROW_LANES];
   logic              win_valid_q;
   logic [ROW_W-1:0]  win_row_q;
   logic [COL_W-1:0]  win_col_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W-1:0] addr;
   logic [1:0]        k;
   logic [ROW_W-1:0]  r;
   logic [COL_W-1:0]  c;
   logic              k_last, c_last, r_last;
   logic              push;

   assign push      = (state_q == PUSH) && !stall;
   assign mem_rd_en = (state_q == FETCH);
   assign mem_addr  = mem_rd_en ? addr : '0;
   assign ifm_read  = push;
   assign ifm_in0   = col_q[0];
   assign ifm_in1   = col_q[1];
   assign ifm_in2   = col_q[2];
   assign win_valid = win_valid_q;
   assign win_row   = win_row_q;
   assign win_col   = win_col_q;
   assign busy      = busy_q;
   assign done      = done_q;

   ifm_addr_gen #(
      .IFM_H  (IFM_H),
      .IFM_W  (IFM_W),
      .ADDR_W (ADDR_W),
      .ROW_W  (ROW_W),
      .COL_W  (COL_W)
   ) u_addr_gen (
      .clk      (clk),
      .rstn     (rstn),
      .load_i   ((state_q == IDLE) && start),
      .base_i   (ifm_base),
      .k_step_i (state_q == FETCH),
      .push_i   (push),
      .addr_o   (addr),
      .k_o      (k),
      .r_o      (r),
      .c_o      (c),
      .k_last_o (k_last),
      .c_last_o (c_last),
      .r_last_o (r_last)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         col_q       <= '{default: '0};
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         win_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FETCH;
                  busy_q  <= 1'b1;
               end
            end
            FETCH: begin
               // SRAM data lags the strobe by one cycle, so lane k-1 lands while lane k is read.
               case (k)
                  2'd1:    col_q[0] <= mem_rd_data;
                  2'd2:    col_q[1] <= mem_rd_data;
                  default: ;
               endcase
               if (k_last) state_q <= LAST;
            end
            LAST: begin
               col_q[2] <= mem_rd_data;
               state_q  <= PUSH;
            end
            PUSH: begin
               if (!stall) begin
                  // Columns 0 and 1 of a row still sit beside the previous row's pixels.
                  if (c >= COL_W'(2)) begin
                     win_valid_q <= 1'b1;
                     win_row_q   <= r;
                     win_col_q   <= c - COL_W'(2);
                  end
                  if (c_last && r_last) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= FETCH;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   a_no_read_in_stall: assert property (@(posedge clk) disable iff (!rstn) ifm_read |-> !stall);
   a_done_pulse:       assert property (@(posedge clk) disable iff (!rstn) done |=> !done);
   a_win_pulse:        assert property (@(posedge clk) disable iff (!rstn) win_valid |=> !win_valid);
endmodule

// File: tb/tb_ifm_feeder.sv
// Bench for ifm_feeder: directed 4x4 traces on one instance, randomized 5x7 scoreboard
// run on a second instance; expectations come from the map geometry and the SRAM image.
module tb_ifm_feeder;
   localparam int AH = 4, AW = 4, AA = 4;
   localparam int BH = 5, BW = 7, BA = 12;

   typedef struct packed {
      int cyc;
      int d0;
      int d1;
      int d2;
      int row;
      int col;
   } ev_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   t0   = 0;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: 4x4 map, 4-bit addresses
   logic                     a_start = 1'b0, a_stall = 1'b0;
   logic [AA-1:0]            a_base = '0;
   logic                     a_rd_en;
   logic [AA-1:0]            a_addr;
   logic signed [7:0]        a_rd_data;
   logic                     a_read, a_wv, a_busy, a_done;
   logic signed [7:0]        a_in0, a_in1, a_in2;
   logic [$clog2(AH)-1:0]    a_wr;
   logic [$clog2(AW)-1:0]    a_wc;
   logic [63:0]              a_outs;

   // Instance B: 5x7 map, 12-bit addresses
   logic                     b_start = 1'b0, b_stall = 1'b0;
   logic [BA-1:0]            b_base = '0;
   logic                     b_rd_en;
   logic [BA-1:0]            b_addr;
   logic signed [7:0]        b_rd_data;
   logic                     b_read, b_wv, b_busy, b_done;
   logic signed [7:0]        b_in0, b_in1, b_in2;
   logic [$clog2(BH)-1:0]    b_wr;
   logic [$clog2(BW)-1:0]    b_wc;
   logic [63:0]              b_outs;

   assign a_outs = 64'({a_rd_en, a_addr, a_read, a_in0, a_in1, a_in2, a_wv, a_wr, a_wc, a_busy, a_done});
   assign b_outs = 64'({b_rd_en, b_addr, b_read, b_in0, b_in1, b_in2, b_wv, b_wr, b_wc, b_busy, b_done});

   ifm_feeder #(.IFM_H(AH), .IFM_W(AW), .ADDR_W(AA)) dut_a (
      .clk(clk), .rstn(rstn), .start(a_start), .ifm_base(a_base), .stall(a_stall),
      .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rd_data(a_rd_data),
      .ifm_read(a_read), .ifm_in0(a_in0), .ifm_in1(a_in1), .ifm_in2(a_in2),
      .win_valid(a_wv), .win_row(a_wr), .win_col(a_wc), .busy(a_busy), .done(a_done)
   );

   ifm_feeder #(.IFM_H(BH), .IFM_W(BW), .ADDR_W(BA)) dut_b (
      .clk(clk), .rstn(rstn), .start(b_start), .ifm_base(b_base), .stall(b_stall),
      .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
      .ifm_read(b_read), .ifm_in0(b_in0), .ifm_in1(b_in1), .ifm_in2(b_in2),
      .win_valid(b_wv), .win_row(b_wr), .win_col(b_wc), .busy(b_busy), .done(b_done)
   );

   logic signed [7:0] mem_a [16];
   logic signed [7:0] mem_b [4096];

   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= mem_a[a_addr];
      if (b_rd_en) b_rd_data <= mem_b[b_addr];
   end

   ev_t a_push_q[$], a_win_q[$], b_push_q[$], b_win_q[$];
   int  a_done_q[$], a_rd_q[$], b_done_q[$];
   ev_t a_ev, b_ev;

   // Event recorder: times are relative to the cycle in which start was driven.
   always @(negedge clk) begin
      a_ev = '{cyc - t0, int'(a_in0), int'(a_in1), int'(a_in2), int'(a_wr), int'(a_wc)};
      b_ev = '{cyc - t0, int'(b_in0), int'(b_in1), int'(b_in2), int'(b_wr), int'(b_wc)};
      if (a_read) begin
         a_push_q.push_back(a_ev);
         $display("push A rel=%0d in=%0d,%0d,%0d", a_ev.cyc, a_ev.d0, a_ev.d1, a_ev.d2);
      end
      if (a_wv)    a_win_q.push_back(a_ev);
      if (a_done)  a_done_q.push_back(cyc - t0);
      if (a_rd_en) a_rd_q.push_back(int'(a_addr));
      if (b_read) begin
         b_push_q.push_back(b_ev);
         $display("push B rel=%0d in=%0d,%0d,%0d", b_ev.cyc, b_ev.d0, b_ev.d1, b_ev.d2);
      end
      if (b_wv)    b_win_q.push_back(b_ev);
      if (b_done)  b_done_q.push_back(cyc - t0);
   end

   function automatic int pix_a(int base, int r, int c);
      return int'(mem_a[(base + r * AW + c) % 16]);
   endfunction

   function automatic int pix_b(int base, int r, int c);
      return int'(mem_b[(base + r * BW + c) % 4096]);
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_a(input int base);
      a_push_q.delete(); a_win_q.delete(); a_done_q.delete(); a_rd_q.delete();
      a_base  = AA'(base);
      a_start = 1'b1;
      t0      = cyc;
      step(1);
      a_start = 1'b0;
   endtask

   task automatic wait_done_a(input int limit);
      for (int i = 0; i < limit && a_done_q.size() == 0; i++) step(1);
      step(2);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step(3);
      n_assert++;
      if (a_outs !== 64'd0) begin
         n_fail++; $display("FAIL reset_a: outputs=%h required 0", a_outs);
      end
      n_assert++;
      if (b_outs !== 64'd0) begin
         n_fail++; $display("FAIL reset_b: outputs=%h required 0", b_outs);
      end
      rstn = 1'b1;
      step(2);
   endtask

   task automatic test_basic();
      int r, c, wr, wc, pi, dc;
      start_a(0);
      for (int j = 0; j < 100 && a_done_q.size() == 0; j++) begin
         if (cyc - t0 == 3) begin
            n_assert++;
            if (a_busy !== 1'b1) begin
               n_fail++; $display("FAIL basic_busy: got %b required 1", a_busy);
            end
         end
         step(1);
      end
      step(2);
      n_assert++;
      if (a_push_q.size() != (AH - 2) * AW) begin
         n_fail++; $display("FAIL basic_push_count: got %0d required %0d", a_push_q.size(), (AH - 2) * AW);
      end
      foreach (a_push_q[p]) begin
         r = p / AW; c = p % AW;
         n_assert++;
         if (a_push_q[p].cyc != 5 + 5 * p || a_push_q[p].d0 != pix_a(0, r, c) ||
             a_push_q[p].d1 != pix_a(0, r + 1, c) || a_push_q[p].d2 != pix_a(0, r + 2, c)) begin
            n_fail++;
            $display("FAIL basic_push[%0d]: got cyc=%0d in=%0d,%0d,%0d required cyc=%0d in=%0d,%0d,%0d", p,
                     a_push_q[p].cyc, a_push_q[p].d0, a_push_q[p].d1, a_push_q[p].d2,
                     5 + 5 * p, pix_a(0, r, c), pix_a(0, r + 1, c), pix_a(0, r + 2, c));
         end
      end
      n_assert++;
      if (a_win_q.size() != (AH - 2) * (AW - 2)) begin
         n_fail++; $display("FAIL basic_win_count: got %0d required %0d", a_win_q.size(), (AH - 2) * (AW - 2));
      end
      foreach (a_win_q[w]) begin
         wr = w / (AW - 2); wc = w % (AW - 2); pi = wr * AW + wc + 2;
         n_assert++;
         if (a_win_q[w].cyc != 5 + 5 * pi + 1 || a_win_q[w].row != wr || a_win_q[w].col != wc ||
             a_win_q[w].d0 != pix_a(0, wr, wc + 2) || a_win_q[w].d1 != pix_a(0, wr + 1, wc + 2) ||
             a_win_q[w].d2 != pix_a(0, wr + 2, wc + 2)) begin
            n_fail++;
            $display("FAIL basic_win[%0d]: got cyc=%0d row=%0d col=%0d in=%0d,%0d,%0d required cyc=%0d row=%0d col=%0d",
                     w, a_win_q[w].cyc, a_win_q[w].row, a_win_q[w].col, a_win_q[w].d0, a_win_q[w].d1,
                     a_win_q[w].d2, 5 + 5 * pi + 1, wr, wc);
         end
      end
      dc = (a_done_q.size() == 1) ? a_done_q[0] : -1;
      n_assert++;
      if (dc != 41) begin
         n_fail++; $display("FAIL basic_done: got cycle %0d (count %0d) required 41", dc, a_done_q.size());
      end
      n_assert++;
      if (a_busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_idle_busy: got %b required 0", a_busy);
      end
   endtask

   task automatic test_stall();
      int r, c, dc;
      start_a(0);
      step(4);
      a_stall = 1'b1;
      for (int j = 5; j <= 9; j++) begin
         #1;
         n_assert++;
         if (a_read !== 1'b0 || a_rd_en !== 1'b0 || a_in0 !== 8'sd0 || a_in1 !== 8'sd4 || a_in2 !== 8'sd8) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got read=%b rd_en=%b in=%0d,%0d,%0d required 0 0 0,4,8",
                     j, a_read, a_rd_en, a_in0, a_in1, a_in2);
         end
         step(1);
      end
      a_stall = 1'b0;
      wait_done_a(100);
      n_assert++;
      if (a_push_q.size() != 8 || a_push_q[0].cyc != 10) begin
         n_fail++; $display("FAIL stall_first_read: got count=%0d first=%0d required 8 at 10",
                            a_push_q.size(), (a_push_q.size() > 0) ? a_push_q[0].cyc : -1);
      end
      foreach (a_push_q[p]) begin
         r = p / AW; c = p % AW;
         n_assert++;
         if (a_push_q[p].cyc != 10 + 5 * p || a_push_q[p].d0 != pix_a(0, r, c) ||
             a_push_q[p].d1 != pix_a(0, r + 1, c) || a_push_q[p].d2 != pix_a(0, r + 2, c)) begin
            n_fail++; $display("FAIL stall_push[%0d]: got cyc=%0d in=%0d,%0d,%0d required cyc=%0d", p,
                               a_push_q[p].cyc, a_push_q[p].d0, a_push_q[p].d1, a_push_q[p].d2, 10 + 5 * p);
         end
      end
      dc = (a_done_q.size() == 1) ? a_done_q[0] : -1;
      n_assert++;
      if (dc != 46) begin
         n_fail++; $display("FAIL stall_done: got cycle %0d required 46", dc);
      end
   endtask

   task automatic test_wrap();
      int r, c;
      int exp_addr [3];
      exp_addr = '{14, 2, 6};
      start_a(14);
      wait_done_a(100);
      n_assert++;
      if (a_rd_q.size() != 24) begin
         n_fail++; $display("FAIL wrap_read_count: got %0d required 24", a_rd_q.size());
      end
      for (int k = 0; k < 3 && k < a_rd_q.size(); k++) begin
         n_assert++;
         if (a_rd_q[k] != exp_addr[k]) begin
            n_fail++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", k, a_rd_q[k], exp_addr[k]);
         end
      end
      foreach (a_push_q[p]) begin
         r = p / AW; c = p % AW;
         n_assert++;
         if (a_push_q[p].d0 != pix_a(14, r, c) || a_push_q[p].d1 != pix_a(14, r + 1, c) ||
             a_push_q[p].d2 != pix_a(14, r + 2, c)) begin
            n_fail++; $display("FAIL wrap_push[%0d]: got in=%0d,%0d,%0d required %0d,%0d,%0d", p,
                               a_push_q[p].d0, a_push_q[p].d1, a_push_q[p].d2,
                               pix_a(14, r, c), pix_a(14, r + 1, c), pix_a(14, r + 2, c));
         end
      end
   endtask

   task automatic test_start_busy();
      int rel, dc;
      start_a(0);
      for (int i = 0; i < 60; i++) begin
         rel = cyc - t0;
         a_start = (rel == 7 || rel == 41);
         if (rel == 42 || rel == 43) begin
            n_assert++;
            if (a_busy !== 1'b0) begin
               n_fail++; $display("FAIL start_at_done[%0d]: busy=%b required 0", rel, a_busy);
            end
         end
         step(1);
      end
      a_start = 1'b0;
      dc = (a_done_q.size() == 1) ? a_done_q[0] : -1;
      n_assert++;
      if (a_push_q.size() != 8 || a_win_q.size() != 4 || dc != 41) begin
         n_fail++; $display("FAIL start_busy_counts: got pushes=%0d wins=%0d done=%0d required 8 4 41",
                            a_push_q.size(), a_win_q.size(), dc);
      end
      start_a(0);
      wait_done_a(100);
      dc = (a_done_q.size() == 1) ? a_done_q[0] : -1;
      n_assert++;
      if (a_push_q.size() != 8 || a_win_q.size() != 4 || dc != 41) begin
         n_fail++; $display("FAIL second_map: got pushes=%0d wins=%0d done=%0d required 8 4 41",
                            a_push_q.size(), a_win_q.size(), dc);
      end
      foreach (a_push_q[p]) begin
         n_assert++;
         if (a_push_q[p].d0 != pix_a(0, p / AW, p % AW) || a_push_q[p].d2 != pix_a(0, p / AW + 2, p % AW)) begin
            n_fail++; $display("FAIL second_map_push[%0d]: got in0=%0d in2=%0d required %0d %0d", p,
                               a_push_q[p].d0, a_push_q[p].d2, pix_a(0, p / AW, p % AW), pix_a(0, p / AW + 2, p % AW));
         end
      end
   endtask

   task automatic test_reset_mid();
      int dc;
      start_a(0);
      step(22);
      rstn = 1'b0;
      step(1);
      n_assert++;
      if (a_outs !== 64'd0) begin
         n_fail++; $display("FAIL reset_mid_outputs: got %h required 0", a_outs);
      end
      step(1);
      rstn = 1'b1;
      step(30);
      n_assert++;
      if (a_done_q.size() != 0 || a_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_abort: got done_count=%0d busy=%b required 0 0", a_done_q.size(), a_busy);
      end
      start_a(0);
      wait_done_a(100);
      dc = (a_done_q.size() == 1) ? a_done_q[0] : -1;
      n_assert++;
      if (a_push_q.size() != 8 || dc != 41) begin
         n_fail++; $display("FAIL reset_restart: got pushes=%0d done=%0d required 8 41", a_push_q.size(), dc);
      end
      foreach (a_push_q[p]) begin
         n_assert++;
         if (a_push_q[p].cyc != 5 + 5 * p || a_push_q[p].d1 != pix_a(0, p / AW + 1, p % AW)) begin
            n_fail++; $display("FAIL reset_restart_push[%0d]: got cyc=%0d in1=%0d required cyc=%0d in1=%0d", p,
                               a_push_q[p].cyc, a_push_q[p].d1, 5 + 5 * p, pix_a(0, p / AW + 1, p % AW));
         end
      end
   endtask

   task automatic test_scoreboard();
      int base, wr, wc, j, dc;
      base = $urandom_range(0, 4095);
      b_push_q.delete(); b_win_q.delete(); b_done_q.delete();
      b_base  = BA'(base);
      b_start = 1'b1;
      t0      = cyc;
      step(1);
      b_start = 1'b0;
      for (int i = 0; i < 3000 && b_done_q.size() == 0; i++) begin
         b_stall = ($urandom_range(0, 2) == 0);
         step(1);
      end
      b_stall = 1'b0;
      step(2);
      dc = (b_done_q.size() == 1) ? b_done_q[0] : -1;
      n_assert++;
      if (dc < 0 || b_push_q.size() != (BH - 2) * BW || b_win_q.size() != (BH - 2) * (BW - 2)) begin
         n_fail++; $display("FAIL sb_counts: got done=%0d pushes=%0d wins=%0d required done>=0 %0d %0d",
                            dc, b_push_q.size(), b_win_q.size(), (BH - 2) * BW, (BH - 2) * (BW - 2));
      end
      foreach (b_push_q[p]) begin
         n_assert++;
         if (b_push_q[p].d0 != pix_b(base, p / BW, p % BW) || b_push_q[p].d1 != pix_b(base, p / BW + 1, p % BW) ||
             b_push_q[p].d2 != pix_b(base, p / BW + 2, p % BW)) begin
            n_fail++; $display("FAIL sb_push[%0d]: got in=%0d,%0d,%0d required %0d,%0d,%0d", p,
                               b_push_q[p].d0, b_push_q[p].d1, b_push_q[p].d2, pix_b(base, p / BW, p % BW),
                               pix_b(base, p / BW + 1, p % BW), pix_b(base, p / BW + 2, p % BW));
         end
      end
      foreach (b_win_q[w]) begin
         wr = w / (BW - 2); wc = w % (BW - 2); j = wr * BW + wc + 2;
         $display("window B rel=%0d row=%0d col=%0d", b_win_q[w].cyc, b_win_q[w].row, b_win_q[w].col);
         n_assert++;
         if (j >= b_push_q.size() || b_win_q[w].row != wr || b_win_q[w].col != wc ||
             b_win_q[w].cyc != b_push_q[j].cyc + 1 ||
             b_win_q[w].d0 != pix_b(base, wr, wc + 2) || b_win_q[w].d1 != pix_b(base, wr + 1, wc + 2) ||
             b_win_q[w].d2 != pix_b(base, wr + 2, wc + 2) ||
             b_push_q[j - 1].d0 != pix_b(base, wr, wc + 1) || b_push_q[j - 1].d2 != pix_b(base, wr + 2, wc + 1) ||
             b_push_q[j - 2].d0 != pix_b(base, wr, wc) || b_push_q[j - 2].d2 != pix_b(base, wr + 2, wc)) begin
            n_fail++; $display("FAIL sb_win[%0d]: got row=%0d col=%0d cyc=%0d required row=%0d col=%0d with golden 3x3 columns",
                               w, b_win_q[w].row, b_win_q[w].col, b_win_q[w].cyc, wr, wc);
         end
      end
      n_assert++;
      if (b_win_q.size() == 0 || b_win_q[b_win_q.size() - 1].cyc != dc) begin
         n_fail++; $display("FAIL sb_done_with_last_win: got done=%0d last_win=%0d required equal", dc,
                            (b_win_q.size() > 0) ? b_win_q[b_win_q.size() - 1].cyc : -1);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
      for (int i = 0; i < 4096; i++) mem_b[i] = 8'($urandom);
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_start_busy();
      test_reset_mid();
      test_scoreboard();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
